// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter that shares the single write port of a FIFO among NREQ producers.
// Optional per-requester accepted-word counters are enabled with FIFO_WR_ARBITER_STAT_EN.
module fifo_wr_arbiter #(
    parameter int NREQ       = 4,
    parameter int DW         = 8,
    parameter int BURST      = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ*DW-1:0]            req_data,
    output logic [NREQ-1:0]               req_ready,
    input  logic                          fifo_full,
    input  logic [$clog2(FIFO_DEPTH):0]   fifo_counter,
    output logic                          fifo_wr_en,
    output logic [DW-1:0]                 fifo_d_in,
    output logic [NREQ-1:0]               grant,
`ifdef FIFO_WR_ARBITER_STAT_EN
    input  logic                          stat_clr,
    output logic [NREQ*16-1:0]            stat_words,
`endif
    output logic                          busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   idx_q, idx_d;
    logic [3:0]      beat_q, beat_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            wr_en_q, wr_en_d;
    logic [DW-1:0]   d_in_q, d_in_d;

    logic            can_write;
    logic            xfer;
    logic            found;
    logic [PW-1:0]   pick;
    logic [PW:0]     cand;
    logic            cur_valid;
    logic [DW-1:0]   cur_data;

    // A registered write still in flight will consume the last free slot.
    assign can_write  = !fifo_full && !(wr_en_q && fifo_counter == CW'(FIFO_DEPTH - 1));
    assign req_ready  = (state_q == S_BURST && can_write) ? grant_q : '0;
    assign xfer       = |(req_valid & req_ready);
    assign grant      = grant_q;
    assign fifo_wr_en = wr_en_q;
    assign fifo_d_in  = d_in_q;
    assign busy       = (state_q == S_BURST);

    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand = {1'b0, rr_ptr_q} + (PW+1)'(off);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (!found && req_valid[cand[PW-1:0]]) begin
                found = 1'b1;
                pick  = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        cur_valid = 1'b0;
        cur_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (idx_q == PW'(i)) begin
                cur_valid = req_valid[i];
                cur_data  = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        idx_d    = idx_q;
        beat_d   = beat_q;
        grant_d  = grant_q;
        wr_en_d  = xfer;
        d_in_d   = xfer ? cur_data : d_in_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d  = NREQ'(1) << pick;
                    idx_d    = pick;
                    rr_ptr_d = (pick == PW'(NREQ - 1)) ? '0 : pick + 1'b1;
                    beat_d   = '0;
                    state_d  = S_BURST;
                end
            end
            S_BURST: begin
                // A stalled but still-valid requester keeps its grant and beat.
                if (xfer) begin
                    if (beat_q == 4'(BURST - 1)) begin
                        grant_d = '0;
                        beat_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end else if (!cur_valid) begin
                    grant_d = '0;
                    beat_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            beat_q   <= '0;
            grant_q  <= '0;
            wr_en_q  <= 1'b0;
            d_in_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            beat_q   <= beat_d;
            grant_q  <= grant_d;
            wr_en_q  <= wr_en_d;
            d_in_q   <= d_in_d;
        end
    end

`ifdef FIFO_WR_ARBITER_STAT_EN
    logic [NREQ-1:0] accept;
    assign accept = req_valid & req_ready;

    // Saturating counters; a clear takes priority over a same-cycle accept.
    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        logic [15:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (stat_clr) begin
                cnt_d = '0;
            end else if (accept[g] && cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign stat_words[g*16 +: 16] = cnt_q;
    end
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the 8-bit, 16-deep `fifo` among NREQ producers.
- Arbitration is round-robin. Each grant is held for a burst of up to BURST words.
- Drives the FIFO write side (`wr_en`, `d_in`) through registered outputs.
- Uses the FIFO's `full` and `fifo_counter` to throttle producers, so that no write is ever issued into a full FIFO.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, data width; must match the FIFO data width.
- BURST, 4, maximum words accepted per grant before re-arbitration (1..15).
- FIFO_DEPTH, 16, FIFO capacity. `fifo_counter` width is $clog2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- req_valid  in  NREQ  per-requester word valid.
- req_data  in  NREQ*DW  per-requester data; requester i uses bits [i*DW +: DW].
- req_ready  out  NREQ  per-requester accept, combinational.
- fifo_full  in  1  FIFO `full` flag.
- fifo_counter  in  5  FIFO occupancy (for FIFO_DEPTH=16).
- fifo_wr_en  out  1  registered write strobe to the FIFO `wr_en`.
- fifo_d_in  out  DW  registered write data to the FIFO `d_in`.
- grant  out  NREQ  registered one-hot current grant; all zero when idle.
- busy  out  1  high while in state BURST.

Behaviour:
- Reset (reset=0, asynchronous):
  - outputs: grant=0, fifo_wr_en=0, fifo_d_in=0, busy=0, req_ready=0;
  - internal: state=IDLE, rr_ptr=0, beat=0.
  - Reset asserted mid-burst drops the grant immediately and cancels any in-flight write. The word being presented that cycle is not considered written.
- can_write = !fifo_full && !(fifo_wr_en && fifo_counter == FIFO_DEPTH-1). The second term accounts for a registered write still in flight.
- req_ready[i] = grant[i] && can_write && state==BURST.
- A transfer occurs when req_valid[i] && req_ready[i] are both high.
- On a transfer:
  - next cycle fifo_wr_en=1 and fifo_d_in=req_data[i] (1-cycle latency from accept to FIFO write);
  - otherwise fifo_wr_en=0 next cycle, and fifo_d_in holds its last value.
- FSM:
  - IDLE:
    - If any req_valid is high, search from index rr_ptr upward, wrapping modulo NREQ. Grant the first valid requester k.
    - Set rr_ptr = (k+1) mod NREQ and beat=0, then go to BURST.
    - Otherwise stay in IDLE.
  - BURST:
    - Each transfer increments beat (4-bit).
    - Release (grant=0, go to IDLE) on the clock edge where either:
      - beat reaches BURST, i.e. a transfer occurs with beat==BURST-1; or
      - req_valid[k] is low at the edge (no transfer that cycle).
- Re-arbitration always passes through IDLE, so there is exactly 1 idle cycle between bursts.
- Full stall:
  - While can_write=0, req_ready is low and beat and grant are held.
  - No timeout; the burst resumes when space appears.
  - A requester that stays valid during the stall keeps its grant.
- Simultaneous requests are resolved purely by rr_ptr rotation, which gives no starvation. Worst-case wait is (NREQ-1) bursts plus NREQ idle cycles.
- Only the FIFO write side is controlled. The read side (`rd_en`) is owned by the consumer and may run concurrently. The occupancy check uses the live fifo_counter.
- Protocol assumption on producers: they hold req_data stable while valid and not ready.

Optional Feature:
- Macro: FIFO_WR_ARBITER_STAT_EN.
- With the macro defined:
  - added ports: stat_clr in 1 and stat_words out NREQ*16;
  - per-requester 16-bit saturating counts of accepted words (hold at 16'hFFFF);
  - stat_clr=1 synchronously zeroes all counters, and clear wins over a same-cycle increment;
  - counters reset to 0 under reset.
- Without the macro: no stat ports, no counters; the core behaviour is identical.

Test Plan:
- Single requester:
  - req_valid=4'b0001 with data 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5.
  - Required: grant=0001 one cycle after valid; 4 writes with fifo_d_in B1..B4 at 1-cycle latency; grant released; 1 idle cycle; re-grant; B5 written.
- Round-robin:
  - All 4 requesters valid continuously.
  - Required: grant sequence 0001, 0010, 0100, 1000, 0001, with 4 words each and 1 idle cycle between bursts.
- Early release:
  - Requester 2 drops valid after 2 words.
  - Required: grant released on that edge; beat restarts at 0 on the next grant; rr_ptr=3.
- Full throttle:
  - Preset fifo_counter=15 with fifo_wr_en=1 in flight.
  - Required: req_ready=0 and no further fifo_wr_en while fifo_full=1; when the consumer pulses rd_en and full deasserts, exactly one word is written, without overflow.
- Reset mid-burst:
  - Drive reset=0 asynchronously between clock edges during beat 2.
  - Required: grant, fifo_wr_en and busy go to 0 immediately; after release, arbitration starts from requester 0.
- Stats (FIFO_WR_ARBITER_STAT_EN):
  - Run the round-robin scenario for 2 full rounds, then pulse stat_clr.
  - Required: each stat_words field reads 8 before the clear and 0 after.
